// File: rtl/float_decoder_if.sv
// Handshake bundle for float_decoder: word-in channel and result-out channel.
// Optional eq_out lane appears only when FLOAT_DECODER_EQ_EN is defined.
interface float_decoder_if;
  logic [31:0] in_data;
  logic        in_balance;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  integer_out;
  logic [3:0]  tenths_out;
  logic        out_valid;
  logic        out_ready;
  logic        parity_err;
  logic        range_err;
`ifdef FLOAT_DECODER_EQ_EN
  logic        eq_out;
`endif

  modport slave (
    input  in_data, in_balance, in_valid, out_ready,
    output in_ready, integer_out, tenths_out, out_valid, parity_err, range_err
`ifdef FLOAT_DECODER_EQ_EN
    , output eq_out
`endif
  );

  modport master (
    output in_data, in_balance, in_valid, out_ready,
    input  in_ready, integer_out, tenths_out, out_valid, parity_err, range_err
`ifdef FLOAT_DECODER_EQ_EN
    , input eq_out
`endif
  );
endinterface

// File: rtl/float_decoder.sv
// Decodes a single-precision word into integer part 0..31 plus one truncated tenths digit.
// Optional FLOAT_DECODER_EQ_EN adds eq_out = (integer_out == tenths_out).
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// INT   | shifting mantissa bits into the integer accumulator, e cycles
// FRAC  | computing the tenths digit from the remaining fraction
// DONE  | result held until out_ready
module float_decoder (
  input  logic           clk,
  input  logic           rst,
  float_decoder_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INT  = 2'd1;
  localparam logic [1:0] S_FRAC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  acc;
  logic [22:0] m;
  logic [2:0]  cnt;
  logic [4:0]  integer_q;
  logic [3:0]  tenths_q;
  logic        parity_q;
  logic        range_q;

  logic        word_zero;
  logic        parity_calc;
  logic        range_calc;
  logic [2:0]  e_cnt;
  logic [26:0] prod;
  logic [3:0]  tenths_calc;

  assign word_zero   = (bus.in_data == 32'd0);
  assign parity_calc = (~^bus.in_data[30:0]) != bus.in_balance;
  assign range_calc  = !word_zero &&
                       (bus.in_data[31] || (bus.in_data[30:23] < 8'd127) ||
                        (bus.in_data[30:23] > 8'd131));
  // exponent-127 modulo 8; exact whenever the exponent is in 127..131
  assign e_cnt       = bus.in_data[25:23] + 3'd1;
  assign prod        = {4'd0, m} * 27'd10;
  assign tenths_calc = 4'(prod >> 23);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      m         <= '0;
      cnt       <= '0;
      integer_q <= '0;
      tenths_q  <= '0;
      parity_q  <= 1'b0;
      range_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            parity_q  <= parity_calc;
            range_q   <= range_calc;
            integer_q <= '0;
            tenths_q  <= '0;
            acc       <= 5'd1;
            m         <= bus.in_data[22:0];
            cnt       <= e_cnt;
            if (parity_calc || range_calc || word_zero)
              state <= S_DONE;
            else if (e_cnt != 3'd0)
              state <= S_INT;
            else
              state <= S_FRAC;
          end
        end
        S_INT: begin
          acc <= {acc[3:0], m[22]};
          m   <= {m[21:0], 1'b0};
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= S_FRAC;
        end
        S_FRAC: begin
          integer_q <= acc;
          tenths_q  <= tenths_calc;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FLOAT_DECODER_EQ_EN
  logic eq_q;

  // zero and error results decode as 0.0, so they compare equal
  always_ff @(posedge clk) begin
    if (rst)
      eq_q <= 1'b0;
    else if (state == S_IDLE && bus.in_valid)
      eq_q <= 1'b1;
    else if (state == S_FRAC)
      eq_q <= (acc == {1'b0, tenths_calc});
  end

  assign bus.eq_out = eq_q;
`endif

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.integer_out = integer_q;
  assign bus.tenths_out  = tenths_q;
  assign bus.parity_err  = parity_q;
  assign bus.range_err   = range_q;
endmodule

// File: tb/tb_float_decoder.sv
// Randomized self-checking bench for float_decoder against a fixed-point value model.
module tb_float_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_decoder_if bus ();
  float_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic exp_active = 1'b0;
  int   exp_int, exp_ten, exp_pe, exp_re;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Value = 1.mantissa * 2^e as 23-bit fixed point; digits taken by plain arithmetic.
  function automatic void model(input logic [31:0] w, input logic bal,
                                output int ii, output int tt, output int pe,
                                output int re, output int lat);
    int     e;
    bit     even;
    longint v, frac;
    even = ($countones(w[30:0]) % 2) == 0;
    pe   = (even != bal) ? 1 : 0;
    e    = int'(w[30:23]) - 127;
    re   = (w != 0 && (w[31] || e < 0 || e > 4)) ? 1 : 0;
    if (pe != 0 || re != 0 || w == 0) begin
      ii = 0; tt = 0; lat = 1;
    end else begin
      v    = (longint'(w[22:0]) | (longint'(1) << 23)) << e;
      ii   = int'(v >> 23);
      frac = v & ((longint'(1) << 23) - 1);
      tt   = int'((frac * 10) >> 23);
      lat  = e + 2;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (!exp_active) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("integer_out", bus.integer_out, exp_int);
        check("tenths_out", bus.tenths_out, exp_ten);
        check("parity_err", bus.parity_err, exp_pe);
        check("range_err", bus.range_err, exp_re);
        check("in_ready_busy", bus.in_ready, 0);
`ifdef FLOAT_DECODER_EQ_EN
        check("eq_out", bus.eq_out, (exp_int == exp_ten) ? 1 : 0);
`endif
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic bal, input int hold);
    int ii, tt, pe, re, lat, n;
    model(w, bal, ii, tt, pe, re, lat);
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", bus.in_ready, 1);
    exp_int = ii; exp_ten = tt; exp_pe = pe; exp_re = re;
    exp_active     = 1'b1;
    bus.in_data    = w;
    bus.in_balance = bal;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    n = 1;
    while (1) begin
      @(negedge clk);
      if (bus.out_valid || n >= 20) break;
      @(posedge clk);
      n++;
    end
    check("latency", bus.out_valid ? n : -1, lat);
    repeat (hold) begin
      bus.in_valid   = 1'($urandom % 2);
      bus.in_data    = $urandom;
      bus.in_balance = 1'($urandom % 2);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_active    = 1'b0;
    @(negedge clk);
    check("valid_drop", bus.out_valid, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  function automatic logic good_bal(input logic [31:0] w);
    return (($countones(w[30:0]) % 2) == 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ii, tt, pe, re, lat;
    logic [31:0] w;
    logic        bal;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_balance = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_integer", bus.integer_out, 0);
    check("rst_tenths", bus.tenths_out, 0);
    check("rst_parity_err", bus.parity_err, 0);
    check("rst_range_err", bus.range_err, 0);
`ifdef FLOAT_DECODER_EQ_EN
    check("rst_eq_out", bus.eq_out, 0);
`endif

    // hand-computed anchors for the model
    model(32'h40B00000, 1'b1, ii, tt, pe, re, lat);
    check("pin_5p5_int", ii, 5);  check("pin_5p5_ten", tt, 5);  check("pin_5p5_lat", lat, 4);
    model(32'h40100000, 1'b1, ii, tt, pe, re, lat);
    check("pin_2p25_int", ii, 2); check("pin_2p25_ten", tt, 2); check("pin_2p25_lat", lat, 3);
    model(32'h3F800000, 1'b0, ii, tt, pe, re, lat);
    check("pin_1p0_int", ii, 1);  check("pin_1p0_ten", tt, 0);  check("pin_1p0_lat", lat, 2);
    model(32'h40B00000, 1'b0, ii, tt, pe, re, lat);
    check("pin_perr", pe, 1);     check("pin_perr_lat", lat, 1);
    model(32'h42000000, good_bal(32'h42000000), ii, tt, pe, re, lat);
    check("pin_32_range", re, 1);
    model(32'hBF800000, good_bal(32'hBF800000), ii, tt, pe, re, lat);
    check("pin_neg_range", re, 1);

    send(32'h40B00000, 1'b1, 0);
    send(32'h40100000, 1'b1, 1);
    send(32'h3F800000, 1'b0, 0);
    send(32'h40B00000, 1'b0, 0);
    send(32'h42000000, good_bal(32'h42000000), 0);
    send(32'hBF800000, good_bal(32'hBF800000), 0);
    send(32'h00000000, 1'b1, 0);
    send(32'h41FFFFFF, good_bal(32'h41FFFFFF), 0);
    send(32'h40B00000, 1'b1, 5);

    // reset while in INT discards the word
    @(negedge clk);
    bus.in_data = 32'h41F00000; bus.in_balance = good_bal(32'h41F00000); bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_integer", bus.integer_out, 0);
    send(32'h40B00000, 1'b1, 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom % 10 == 0) begin
        w = 32'd0;
      end else begin
        w[31]    = ($urandom % 8 == 0);
        w[30:23] = 8'(124 + $urandom % 10);
        w[22:0]  = 23'($urandom);
      end
      bal = good_bal(w);
      if ($urandom % 6 == 0) bal = ~bal;
      send(w, bal, int'($urandom % 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
